// File: rtl/base_afreq_pkg.sv
// rtl/base_afreq_pkg.sv - shared constants and select-width helper for the pair arbiter
package base_afreq_pkg;

    localparam logic PH_FIRST  = 1'b0;
    localparam logic PH_SECOND = 1'b1;

    function automatic int sel_w(input int ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// rtl/base_rr_pick.sv - combinational round-robin picker, first request at or after ptr with wrap
module base_rr_pick
    import base_afreq_pkg::*;
#(
    parameter int ways = 4,
    localparam int SW  = sel_w(ways)
) (
    input  logic [ways-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            gnt_v,
    output logic [SW-1:0]   gnt_idx
);

    int j;

    // Scan from the far end so the last hit is the nearest one to ptr.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int i = ways - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= ways) begin
                j = j - ways;
            end
            if (req[j]) begin
                gnt_v   = 1'b1;
                gnt_idx = SW'(j);
            end
        end
    end

endmodule

// File: rtl/base_afreq_pair_arb.sv
// rtl/base_afreq_pair_arb.sv - round-robin arbiter locking its grant for two-beat down-converter pairs
module base_afreq_pair_arb
    import base_afreq_pkg::*;
#(
    parameter int ways  = 4,
    parameter int width = 1,
    localparam int SW   = sel_w(ways)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ways-1:0]         en,
    input  logic [ways-1:0]         i_v,
    output logic [ways-1:0]         i_r,
    input  logic [ways*width-1:0]   i_d,
    output logic                    o_v,
    input  logic                    o_r,
    output logic [width-1:0]        o_d,
    output logic [SW-1:0]           o_sel,
    output logic                    o_phase
);

    logic          phase_q, phase_d;
    logic [SW-1:0] lock_sel_q, lock_sel_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] last_sel_q, last_sel_d;

    logic [ways-1:0] cand;
    logic            pick_v;
    logic [SW-1:0]   pick_idx;
    logic [SW-1:0]   grant;
    logic            grant_live;
    logic            accept;

    // Candidates are gated by reset so nothing is offered while the block is held in reset.
    assign cand = i_v & en & {ways{reset}};

    base_rr_pick #(
        .ways (ways)
    ) u_pick (
        .req     (cand),
        .ptr     (rr_ptr_q),
        .gnt_v   (pick_v),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        grant      = last_sel_q;
        grant_live = 1'b0;
        o_v        = 1'b0;
        if (phase_q == PH_SECOND) begin
            grant      = lock_sel_q;
            grant_live = 1'b1;
            o_v        = i_v[lock_sel_q];
        end else if (pick_v) begin
            grant      = pick_idx;
            grant_live = 1'b1;
            o_v        = 1'b1;
        end
    end

    always_comb begin
        i_r = '0;
        if (grant_live) begin
            i_r[grant] = o_r;
        end
    end

    assign o_d     = i_d[int'(grant)*width +: width];
    assign o_sel   = (ways == 1) ? '0 : grant;
    assign o_phase = phase_q;
    assign accept  = o_v & o_r;

    always_comb begin
        phase_d    = phase_q;
        lock_sel_d = lock_sel_q;
        rr_ptr_d   = rr_ptr_q;
        last_sel_d = o_sel;
        if (accept) begin
            if (phase_q == PH_FIRST) begin
                phase_d    = PH_SECOND;
                lock_sel_d = grant;
            end else begin
                phase_d = PH_FIRST;
                if (int'(lock_sel_q) >= ways - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = lock_sel_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= PH_FIRST;
            lock_sel_q <= '0;
            rr_ptr_q   <= '0;
            last_sel_q <= '0;
        end else begin
            phase_q    <= phase_d;
            lock_sel_q <= lock_sel_d;
            rr_ptr_q   <= rr_ptr_d;
            last_sel_q <= last_sel_d;
        end
    end

endmodule

// File: tb/tb_base_afreq_pair_arb.sv
// tb/tb_base_afreq_pair_arb.sv - directed scoreboard bench for the pair arbiter
module tb_base_afreq_pair_arb;

    localparam int WAYS = 4;
    localparam int W    = 8;

    logic              clk;
    logic              reset;
    logic [WAYS-1:0]   en;
    logic [WAYS-1:0]   i_v;
    logic [WAYS-1:0]   i_r;
    logic [WAYS*W-1:0] i_d;
    logic              o_v;
    logic              o_r;
    logic [W-1:0]      o_d;
    logic [1:0]        o_sel;
    logic              o_phase;

    int checks = 0;
    int errors = 0;

    logic [3:0] cnt [WAYS];

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic       ph;
        logic [3:0] ir;
        logic [7:0] d;
    } exp_t;

    exp_t sbq[$];

    base_afreq_pair_arb #(
        .ways  (WAYS),
        .width (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_d     (o_d),
        .o_sel   (o_sel),
        .o_phase (o_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            i_d[k*W +: W] = {4'(k), cnt[k]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expectation for this cycle, then pop and compare it away from the clock edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic ph);
        exp_t e;
        exp_t g;
        e.v   = v;
        e.sel = sel;
        e.ph  = ph;
        e.ir  = (v || ph) ? (4'(o_r) << sel) : 4'b0000;
        e.d   = {2'b00, sel, cnt[sel]};
        sbq.push_back(e);
        @(negedge clk);
        g = sbq.pop_front();
        chk("o_v", 32'(o_v), 32'(g.v));
        chk("o_sel", 32'(o_sel), 32'(g.sel));
        chk("o_phase", 32'(o_phase), 32'(g.ph));
        chk("i_r", 32'(i_r), 32'(g.ir));
        if (g.v) begin
            chk("o_d", 32'(o_d), 32'(g.d));
        end
        if (g.v && o_r) begin
            cnt[g.sel] = cnt[g.sel] + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < WAYS; k++) cnt[k] = 4'd0;
        reset = 1'b0;
        en    = 4'hF;
        i_v   = 4'hF;
        o_r   = 1'b1;

        // Held in reset with everyone requesting.
        #2;
        chk("rst_o_v", 32'(o_v), 32'd0);
        chk("rst_i_r", 32'(i_r), 32'd0);
        chk("rst_o_sel", 32'(o_sel), 32'd0);
        chk("rst_o_phase", 32'(o_phase), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fairness: pairs 0,0,1,1,2,2,3,3,0,0.
        step(1, 0, 0); step(1, 0, 1);
        step(1, 1, 0); step(1, 1, 1);
        step(1, 2, 0); step(1, 2, 1);
        step(1, 3, 0); step(1, 3, 1);
        step(1, 0, 0); step(1, 0, 1);

        // Lock hold: req1 gaps for three cycles while req2 waits.
        i_v = 4'b0110;
        step(1, 1, 0);
        i_v = 4'b0100;
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        i_v = 4'b0110;
        step(1, 1, 1);
        i_v = 4'b0100;
        step(1, 2, 0); step(1, 2, 1);

        // Mask: only 0 and 2 enabled; dropping en[2] mid-pair keeps the pair.
        i_v = 4'hF;
        en  = 4'b0101;
        step(1, 0, 0); step(1, 0, 1);
        step(1, 2, 0);
        en  = 4'b0001;
        step(1, 2, 1);
        step(1, 0, 0); step(1, 0, 1);
        en  = 4'b0000;
        step(0, 0, 0); step(0, 0, 0);

        // Backpressure with req3 alone.
        en  = 4'hF;
        i_v = 4'b1000;
        o_r = 1'b1; step(1, 3, 0);
        o_r = 1'b0; step(1, 3, 1);
        o_r = 1'b1; step(1, 3, 1);
        o_r = 1'b0; step(1, 3, 0);
        o_r = 1'b1; step(1, 3, 0);

        // Reset mid-pair acts without a clock edge.
        chk("pre_rst_phase", 32'(o_phase), 32'd1);
        i_v   = 4'hF;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_o_phase", 32'(o_phase), 32'd0);
        chk("midrst_o_sel", 32'(o_sel), 32'd0);
        chk("midrst_o_v", 32'(o_v), 32'd0);
        chk("midrst_i_r", 32'(i_r), 32'd0);
        chk("midrst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 0, 0); step(1, 0, 1);
        step(1, 1, 0);

        chk("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/base_afreq_pair_arb.md
# base_afreq_pair_arb

Round-robin arbiter that shares one 2:1 frequency down-converter input channel among `ways` valid/ready requesters. It sits directly upstream of the down-converter's `i_v/i_r/i_d` port. The down-converter packs consecutive beats into `o_d0/o_d1` pairs, so the arbiter locks its grant for exactly two accepted beats. This guarantees a pair never mixes data from two requesters, and the arbiter's phase always matches the down-converter's phase.

## Interface
- `ways`, default 4: number of requesters, ≥1.
- `width`, default 1: data width per beat.
- `clk`  input  1  clock; shared by the arbiter and the down-converter high-rate side.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  `ways`  per-requester enable mask; sampled only when choosing a new grant.
- `i_v`  input  `ways`  requester valid.
- `i_r`  output  `ways`  requester ready.
- `i_d`  input  `ways*width`  requester data; requester k occupies `[k*width +: width]`.
- `o_v`  output  1  valid to the down-converter.
- `o_r`  input  1  ready from the down-converter.
- `o_d`  output  `width`  muxed data.
- `o_sel`  output  `max(1,$clog2(ways))`  current grantee index.
- `o_phase`  output  1  0 = next accepted beat is first of pair, 1 = second.

## Operation
- State: `phase` (1 bit), `lock_sel` (grantee), `rr_ptr` (highest-priority index).
- **Phase 0 (IDLE):**
  - Candidates are `i_v & en`.
  - Grant goes to the first candidate at or after `rr_ptr`, scanning upward with wrap.
  - If there are no candidates, `o_v`=0. `o_sel` holds its last value (0 after reset), and all `i_r` are 0.
- **Phase 1 (LOCKED):**
  - Grant = `lock_sel` regardless of `en` or other requesters' `i_v`.
  - `o_v` = `i_v[lock_sel]`. A gap from the grantee stalls the channel, and the lock is not released.
- **Pass-through (both phases):** `o_d` = grantee data, `i_r[grant]` = `o_r`, all other `i_r` = 0.
- **Accept** = `o_v & o_r`.
  - Accept in phase 0: `lock_sel` ← grant, `phase` ← 1.
  - Accept in phase 1: `phase` ← 0, `rr_ptr` ← `lock_sel`+1, wrapping at `ways` (not at 2^N).
- **Enable mask:**
  - Deasserting `en[k]` while k is locked does not break the pair.
  - `en`=0 for all requesters leaves the arbiter idle in phase 0.
- **`ways`=1:** `o_sel` is tied to 0. The block reduces to a phase tracker with pass-through.
- **Reset values:** `phase`=0, `rr_ptr`=0, `lock_sel`=0, `o_v`=0, `i_r`=0, `o_sel`=0, `o_phase`=0.
- **Reset mid-pair:** drops the half pair. The down-converter must share the same reset.

## Timing
- Zero-cycle data latency: `o_v`, `o_d`, and `i_r` are combinational from inputs and state.
- There is no combinational path from `o_r` to `o_v` or to `o_sel`.
- The path from `o_r` to `i_r` is combinational; only the granted bit follows `o_r`.
- Grant changes only on the clock edge following a phase-1 accept, or combinationally while in phase 0.
- Peak throughput is one beat per cycle. Back-to-back pairs from different requesters need no bubble.
- **Simultaneous requests in phase 0:** the winner is fixed by `rr_ptr`. A requester asserting valid in the same cycle gets no preference.
- A requester must hold `i_v` and data stable until accepted. The arbiter does not check this.

## Structure
- Package `base_afreq_pkg`: `sel_w(ways)` function (`max(1,$clog2(ways))`) and phase encoding constants `PH_FIRST`=0 and `PH_SECOND`=1.
- Sub-module `base_rr_pick`:
  - Combinational round-robin picker with inputs `req[ways]` and `ptr`, and outputs `gnt_v` and `gnt_idx`.
  - It is reusable by future multi-channel arbiters.
- Top level holds the phase/lock/pointer flops (async clear on `reset` low) and the data mux.

## Test plan
- **Reset:** with `reset`=0 and all `i_v`=1, expect `o_v`=0 and `i_r`=0. After release, the first grant is req0.
- **Fairness:** `ways`=4, all `i_v`=1, `en`=4'hF, `o_r`=1. Expect pairs granted 0,0,1,1,2,2,3,3,0,0, with `o_phase` toggling every cycle.
- **Lock hold:**
  - Req1 is accepted in phase 0, then drops `i_v` for 3 cycles while req2 is valid. Expect `o_v`=0 for those 3 cycles and `o_sel`=1.
  - Req1's next beat completes the pair, and then req2 is granted.
- **Mask:**
  - `en`=4'b0101 with all valid: grants alternate 0,0,2,2.
  - Clearing `en[2]` during req2's phase 1 still completes req2's pair.
- **Backpressure:** `o_r` toggles 1,0,1,0 with req3 alone valid. Expect `i_r[3]` to mirror `o_r`, and `o_phase` to advance only on cycles where `o_r`=1.
- **Mid-pair reset:** assert `reset` low while `o_phase`=1. Expect `o_phase`=0, `o_sel`=0, and `rr_ptr`=0 immediately, without waiting for a clock edge.
